cla_adder: RTL and testbench
============================

Name: cla_adder

Overview:
Parameterised hierarchical carry-lookahead adder used in the datapath (HCLA) for fast w-bit addition. It computes a + b + c_in using 4-bit lookahead groups and a second-level group lookahead, with no ripple between groups. Result and carry-out are registered once on the clock, giving a fixed 1-cycle latency.

Parameters:
width, 4, operand/result bit width; any integer >= 1. Internally padded with zeros up to a multiple of 4.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
a  input  width  operand A, unsigned
b  input  width  operand B, unsigned
c_in  input  1  carry-in
c_out  output  1  registered carry-out of bit width-1
sum  output  width  registered sum, (a + b + c_in) mod 2^width

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- rst_n low: sum = 0 and c_out = 0 immediately, independent of clk. Both hold while rst_n is low.
- Reset deassertion is synchronised to clk by the surrounding system. The first capture happens at the first rising edge with rst_n high.
- Latency: on every rising clk edge with rst_n high, {c_out, sum} <= a + b + c_in, using the a/b/c_in values sampled at that edge. The outputs reflect the inputs one cycle earlier.
- There is no enable or handshake. The block captures on every cycle.
- Bit level: p_i = a_i XOR b_i and g_i = a_i AND b_i. The carries are c_{i+1} = g_i OR (p_i AND c_i), computed by lookahead expansion, not ripple.
- Group level, per 4-bit group k: P_k = AND of its p bits, and G_k = g3 | p3g2 | p3p2g1 | p3p2p1g0.
- Group carries into each group come from a second-level lookahead on (P_k, G_k) and c_in. For width > 16, a third level is added so no carry ever ripples across groups.
- sum_i = p_i XOR c_i.
- c_out is the carry out of bit width-1, not of the padded MSB. Padding bits must not affect c_out.
- Arithmetic is unsigned. Overflow wraps modulo 2^width and is signalled only through c_out. There is no signed-overflow flag.
- Reset asserted mid-operation clears the outputs immediately. The in-flight result is discarded.
- X or Z on the inputs is not handled specially.

Decomposition:
- Shared package (datapath_pkg):
  - constant CLA_GROUP = 4;
  - function that computes the padded width as ceil(width/4)*4.
- Natural sub-module: cla_group4, a combinational 4-bit lookahead unit.
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: s[3:0], group propagate P, group generate G.
- The top level instantiates ceil(width/4) cla_group4 units.
- The top level also contains the multi-level carry-lookahead logic and the output register.

Test Plan:
- Reset: assert rst_n = 0 between clock edges with a=4'b0111, b=4'b1101 -> sum=0 and c_out=0 immediately, with no clock edge needed.
- Basic sums, width=4, c_in=0, one-cycle latency:
  - a=0, b=0 -> sum=0, c_out=0
  - a=1, b=4 -> sum=5, c_out=0
  - a=2, b=0 -> sum=2, c_out=0
  - a=3, b=4 -> sum=7, c_out=0
  - a=4, b=6 -> sum=10, c_out=0
- Overflow, width=4:
  - a=7, b=13 -> sum=4, c_out=1
  - a=13, b=8 -> sum=5, c_out=1
  - a=15, b=15, c_in=1 -> sum=15, c_out=1
- Full propagate chain: a=4'hF, b=0, c_in=1 -> sum=0, c_out=1. Repeat at width=16 with a=16'hFFFF -> sum=0, c_out=1 (exercises cross-group lookahead).
- Non-multiple-of-4 width, width=6: a=6'h3F, b=1, c_in=0 -> sum=0, c_out=1. Also a=6'h20, b=6'h20 -> sum=0, c_out=1.
- Randomised: 1000 random a/b/c_in vectors at widths 4, 6, 16 and 32 -> {c_out, sum} equals a + b + c_in one cycle later. Include one rst_n pulse mid-stream -> outputs clear at once, and correct results resume on the first edge after release.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared datapath constants and 4-bit carry-lookahead helpers used by the
// hierarchical carry-lookahead adder.
package datapath_pkg;

    localparam int CLA_GROUP = 4;

    // Operand width rounded up to a whole number of lookahead groups.
    function automatic int cla_pad_width(input int w);
        return ((w + CLA_GROUP - 1) / CLA_GROUP) * CLA_GROUP;
    endfunction

    // Internal carries c1..c3 of a 4-wide lookahead block, fully expanded.
    function automatic logic [2:0] cla4_carries(input logic [3:0] p,
                                                input logic [3:0] g,
                                                input logic       c0);
        logic [2:0] c;
        c[0] = g[0] | (p[0] & c0);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    function automatic logic cla4_generate(input logic [3:0] p,
                                           input logic [3:0] g);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    endfunction

endpackage

// File: rtl/cla_adder_group4.sv
// Combinational 4-bit lookahead unit: sum bits plus group propagate/generate
// for the next lookahead level.
module cla_group4
    import datapath_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       P,
    output logic       G
);

    logic [3:0] bit_p;
    logic [3:0] bit_g;
    logic [2:0] bit_c;

    assign bit_p = a ^ b;
    assign bit_g = a & b;
    assign bit_c = cla4_carries(bit_p, bit_g, cin);

    assign s = bit_p ^ {bit_c, cin};
    assign P = &bit_p;
    assign G = cla4_generate(bit_p, bit_g);

endmodule

// File: rtl/cla_adder.sv
// Registered hierarchical carry-lookahead adder: 4-bit groups, a lookahead
// over groups of four groups, and a flat lookahead across those super-groups.
module cla_adder
    import datapath_pkg::*;
#(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             c_in,
    output logic             c_out,
    output logic [width-1:0] sum
);

    localparam int PW = cla_pad_width(width);
    localparam int NG = PW / CLA_GROUP;
    localparam int NS = (NG + CLA_GROUP - 1) / CLA_GROUP;

    logic [PW-1:0]     a_pad;
    logic [PW-1:0]     b_pad;
    logic [PW-1:0]     sum_pad;
    logic [4*NS-1:0]   gp;
    logic [4*NS-1:0]   gg;
    logic [NS-1:0]     sp;
    logic [NS-1:0]     sg;
    logic [NS:0]       sc;
    logic [4*NS:0]     gc;
    logic [2:0]        la_c;
    logic              prod;
    logic              term;
    logic              c_out_d;
    logic [width-1:0]  sum_q;
    logic              c_out_q;
    logic              unused_sink;

    assign a_pad = PW'(a);
    assign b_pad = PW'(b);

    // Groups beyond NG only fill out the last super-group; P=G=0 keeps them inert.
    for (genvar k = 0; k < 4 * NS; k++) begin : g_grp
        if (k < NG) begin : g_unit
            cla_group4 u_grp (
                .a   (a_pad[4*k +: 4]),
                .b   (b_pad[4*k +: 4]),
                .cin (gc[k]),
                .s   (sum_pad[4*k +: 4]),
                .P   (gp[k]),
                .G   (gg[k])
            );
        end else begin : g_pad
            assign gp[k] = 1'b0;
            assign gg[k] = 1'b0;
        end
    end

    always_comb begin
        sp = '0;
        sg = '0;
        for (int j = 0; j < NS; j++) begin
            sp[j] = &gp[4*j +: 4];
            sg[j] = cla4_generate(gp[4*j +: 4], gg[4*j +: 4]);
        end
    end

    // Top level: each super-group carry is a sum of products, never a chain.
    always_comb begin
        sc    = '0;
        term  = 1'b0;
        prod  = 1'b0;
        sc[0] = c_in;
        for (int j = 0; j < NS; j++) begin
            term = 1'b0;
            for (int m = 0; m <= j; m++) begin
                prod = sg[m];
                for (int n = m + 1; n <= j; n++) begin
                    prod = prod & sp[n];
                end
                term = term | prod;
            end
            prod = c_in;
            for (int n = 0; n <= j; n++) begin
                prod = prod & sp[n];
            end
            sc[j+1] = term | prod;
        end
    end

    always_comb begin
        gc   = '0;
        la_c = '0;
        for (int j = 0; j < NS; j++) begin
            la_c        = cla4_carries(gp[4*j +: 4], gg[4*j +: 4], sc[j]);
            gc[4*j]     = sc[j];
            gc[4*j + 1] = la_c[0];
            gc[4*j + 2] = la_c[1];
            gc[4*j + 3] = la_c[2];
        end
        gc[4*NS] = sc[NS];
    end

    // With zero padding above bit width-1, the padded sum bit at position
    // width is exactly the carry out of bit width-1.
    if (PW == width) begin : g_cout_full
        assign c_out_d = gc[NG];
    end else begin : g_cout_pad
        assign c_out_d = sum_pad[width];
    end

    assign unused_sink = ^{gc, sum_pad};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            sum_q   <= sum_pad[width-1:0];
            c_out_q <= c_out_d;
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;

endmodule

// File: tb/tb_cla_adder.sv
// Directed-vector and randomised checks of cla_adder at widths 4, 6, 16, 32.
module tb_cla_adder;

    typedef struct {
        int          w;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  a4,  b4,  sum4;
    logic [5:0]  a6,  b6,  sum6;
    logic [15:0] a16, b16, sum16;
    logic [31:0] a32, b32, sum32;
    logic        cin4, cin6, cin16, cin32;
    logic        co4, co6, co16, co32;

    int checks;
    int errors;

    vec_t vecs[$];
    logic [32:0] exp_q4[$];
    logic [32:0] exp_q6[$];
    logic [32:0] exp_q16[$];
    logic [32:0] exp_q32[$];

    cla_adder #(.width(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .c_in(cin4),
        .c_out(co4), .sum(sum4)
    );
    cla_adder #(.width(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .a(a6), .b(b6), .c_in(cin6),
        .c_out(co6), .sum(sum6)
    );
    cla_adder #(.width(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .c_in(cin16),
        .c_out(co16), .sum(sum16)
    );
    cla_adder #(.width(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .a(a32), .b(b32), .c_in(cin32),
        .c_out(co32), .sum(sum32)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard comparison
    task automatic check(input string name, input logic [32:0] got,
                         input logic [32:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_w4"},  33'({co4, sum4}),   33'd0);
        check({name, "_w6"},  33'({co6, sum6}),   33'd0);
        check({name, "_w16"}, 33'({co16, sum16}), 33'd0);
        check({name, "_w32"}, 33'({co32, sum32}), 33'd0);
    endtask

    // Drivers
    task automatic add_vec(input int w, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic [31:0] s, input logic co);
        vec_t v;
        v.w = w; v.a = a; v.b = b; v.cin = cin; v.sum = s; v.cout = co;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        case (v.w)
            4:       begin a4  = v.a[3:0];  b4  = v.b[3:0];  cin4  = v.cin; end
            6:       begin a6  = v.a[5:0];  b6  = v.b[5:0];  cin6  = v.cin; end
            16:      begin a16 = v.a[15:0]; b16 = v.b[15:0]; cin16 = v.cin; end
            default: begin a32 = v.a;       b32 = v.b;       cin32 = v.cin; end
        endcase
    endtask

    function automatic logic [32:0] got_of(input int w);
        case (w)
            4:       return 33'({co4, sum4});
            6:       return 33'({co6, sum6});
            16:      return 33'({co16, sum16});
            default: return {co32, sum32};
        endcase
    endfunction

    task automatic apply_vec(input vec_t v, input int idx);
        logic [32:0] exp;
        exp = 33'(v.sum);
        exp[v.w] = v.cout;
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        check($sformatf("vec%0d_w%0d", idx, v.w), got_of(v.w), exp);
    endtask

    task automatic drive_random();
        a4  = 4'($urandom());  b4  = 4'($urandom());  cin4  = 1'($urandom_range(0, 1));
        a6  = 6'($urandom());  b6  = 6'($urandom());  cin6  = 1'($urandom_range(0, 1));
        a16 = 16'($urandom()); b16 = 16'($urandom()); cin16 = 1'($urandom_range(0, 1));
        a32 = $urandom();      b32 = $urandom();      cin32 = 1'($urandom_range(0, 1));
        exp_q4.push_back(33'(5'(a4) + 5'(b4) + 5'(cin4)));
        exp_q6.push_back(33'(7'(a6) + 7'(b6) + 7'(cin6)));
        exp_q16.push_back(33'(17'(a16) + 17'(b16) + 17'(cin16)));
        exp_q32.push_back(33'(a32) + 33'(b32) + 33'(cin32));
    endtask

    task automatic pop_check(input int idx);
        if (exp_q4.size() != 0) begin
            check($sformatf("rnd%0d_w4", idx),  33'({co4, sum4}),   exp_q4.pop_front());
            check($sformatf("rnd%0d_w6", idx),  33'({co6, sum6}),   exp_q6.pop_front());
            check($sformatf("rnd%0d_w16", idx), 33'({co16, sum16}), exp_q16.pop_front());
            check($sformatf("rnd%0d_w32", idx), {co32, sum32},      exp_q32.pop_front());
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        a4 = '0;  b4 = '0;  cin4 = 1'b0;
        a6 = '0;  b6 = '0;  cin6 = 1'b0;
        a16 = '0; b16 = '0; cin16 = 1'b0;
        a32 = '0; b32 = '0; cin32 = 1'b0;

        add_vec(4,  32'd0,  32'd0,  1'b0, 32'd0,  1'b0);
        add_vec(4,  32'd1,  32'd4,  1'b0, 32'd5,  1'b0);
        add_vec(4,  32'd2,  32'd0,  1'b0, 32'd2,  1'b0);
        add_vec(4,  32'd3,  32'd4,  1'b0, 32'd7,  1'b0);
        add_vec(4,  32'd4,  32'd6,  1'b0, 32'd10, 1'b0);
        add_vec(4,  32'd7,  32'd13, 1'b0, 32'd4,  1'b1);
        add_vec(4,  32'd13, 32'd8,  1'b0, 32'd5,  1'b1);
        add_vec(4,  32'd15, 32'd15, 1'b1, 32'd15, 1'b1);
        add_vec(4,  32'hF,  32'd0,  1'b1, 32'd0,  1'b1);
        add_vec(16, 32'hFFFF, 32'd0,    1'b1, 32'd0,     1'b1);
        add_vec(16, 32'h0F0F, 32'h00F1, 1'b0, 32'h1000,  1'b0);
        add_vec(16, 32'h8000, 32'h8000, 1'b0, 32'd0,     1'b1);
        add_vec(6,  32'h3F, 32'h01, 1'b0, 32'd0,   1'b1);
        add_vec(6,  32'h20, 32'h20, 1'b0, 32'd0,   1'b1);
        add_vec(6,  32'h15, 32'h0A, 1'b1, 32'h20,  1'b0);
        add_vec(32, 32'hFFFF_FFFF, 32'd0,         1'b1, 32'd0,         1'b1);
        add_vec(32, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0);
        add_vec(32, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'd0,         1'b1);

        // Reset state, then release between edges
        #2;
        check_all_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset clears a live result without a clock edge
        @(negedge clk);
        a4 = 4'b0111; b4 = 4'b1101; cin4 = 1'b0;
        @(posedge clk);
        #1;
        check("pre_reset_w4", 33'({co4, sum4}), 33'h14);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear_w4", 33'({co4, sum4}), 33'd0);
        @(posedge clk);
        #1;
        check("reset_hold_w4", 33'({co4, sum4}), 33'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Output must not follow inputs until the next edge
        @(negedge clk);
        a4 = 4'd1; b4 = 4'd4; cin4 = 1'b0;
        @(posedge clk);
        #1;
        check("latency_cap_w4", 33'({co4, sum4}), 33'd5);
        a4 = 4'd2; b4 = 4'd0;
        #1;
        check("latency_hold_w4", 33'({co4, sum4}), 33'd5);
        @(posedge clk);
        #1;
        check("latency_next_w4", 33'({co4, sum4}), 33'd2);

        foreach (vecs[i]) apply_vec(vecs[i], i);

        // Randomised stream across all widths with a reset pulse mid-stream
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            pop_check(i);
            if (i == 120) begin
                #2;
                rst_n = 1'b0;
                #1;
                check_all_zero("mid_reset");
                exp_q4.delete(); exp_q6.delete(); exp_q16.delete(); exp_q32.delete();
                @(posedge clk);
                #1;
                check_all_zero("mid_reset_hold");
                @(negedge clk);
                rst_n = 1'b1;
            end
            drive_random();
        end
        @(negedge clk);
        pop_check(250);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
